uart_tx_fifo: RTL

- Buffered, parametrised UART transmitter. Next generation of the team's single-frame UART TX.
- Accepts words over a valid/ready stream into an internal FIFO and serialises them back-to-back, LSB first.
- Bit period, stop-bit count and parity mode are set at runtime per frame.
- Sits between the on-chip stream fabric and the tx pad.

---
 rtl/uart_tx_fifo.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: stream input into a circular FIFO, frames sent back-to-back, LSB first.
// Optional parity bit generation is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int BITS_PER_WORD = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int DIV_W         = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [BITS_PER_WORD-1:0]      s_data,
    input  logic [DIV_W-1:0]              clks_per_bit,
    input  logic                          stop2,
    input  logic [1:0]                    parity_mode,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(BITS_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e                   state_q, state_d;
    logic [BITS_PER_WORD-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]         div_q, div_d, baud_q, baud_d;
    logic [BCW-1:0]           bitc_q, bitc_d;
    logic                     stop2_q, stop2_d;
    logic                     tx_q, tx_d;
    logic                     done_q, done_d;
    logic                     push, pop, load, bit_end;
    logic [BITS_PER_WORD-1:0] head;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d, par_bit_q, par_bit_d;
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    assign s_ready    = (count_q != CW'(FIFO_DEPTH));
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign tx         = tx_q;
    assign tx_done    = done_q;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        push     = s_valid && s_ready;
        pop      = 1'b0;
        load     = 1'b0;
        state_d  = state_q;
        shift_d  = shift_q;
        div_d    = div_q;
        stop2_d  = stop2_q;
        bitc_d   = bitc_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        bit_end  = (baud_q == div_q - DIV_W'(1));
        baud_d   = baud_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bitc_q == BCW'(BITS_PER_WORD - 1)) begin
                        bitc_d = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else
`endif
                        begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitc_d = bitc_q + BCW'(1);
                        tx_d   = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // bitc counts stop bits here: 0 = first, 1 = second
                    if (stop2_q && bitc_q == '0) begin
                        bitc_d = BCW'(1);
                    end else begin
                        done_d = 1'b1;
                        if (count_q != '0) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start: pop head word and freeze runtime settings for the whole frame.
        if (load) begin
            pop     = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
            shift_d = head;
            div_d   = (clks_per_bit == '0) ? DIV_W'(1) : clks_per_bit;
            stop2_d = stop2;
            bitc_d  = '0;
            baud_d  = '0;
`ifdef UART_TX_PARITY_EN
            par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d = (^head) ^ (parity_mode == 2'b10);
`endif
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shift_q  <= '0;
            div_q    <= DIV_W'(1);
            baud_q   <= '0;
            bitc_q   <= '0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            baud_q   <= baud_d;
            bitc_q   <= bitc_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

endmodule
